// File: rtl/bist_seq_checker_if.sv
// Vector-issue / result-return bundle between the BIST checker and the unit under test.
interface bist_seq_checker_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 3
);
  logic             vec_valid;
  logic [IDX_W-1:0] vec_idx;
  logic             res_valid;
  logic [WIDTH-1:0] primary_res;
  logic             primary_carry;

  modport master (
    output vec_valid, vec_idx,
    input  res_valid, primary_res, primary_carry
  );

  modport slave (
    input  vec_valid, vec_idx,
    output res_valid, primary_res, primary_carry
  );
endinterface

// File: rtl/bist_seq_checker.sv
// Built-in self-test sequencer: issues NUM_VEC vectors, compares {carry,result}
// against a golden table, counts mismatches/timeouts and raises a sticky fault.
module bist_seq_checker #(
  parameter  int unsigned                      WIDTH   = 32,
  parameter  int unsigned                      NUM_VEC = 8,
  parameter  logic [NUM_VEC*(WIDTH+1)-1:0]     GOLDEN  = '0,
  parameter  int unsigned                      TIMEOUT = 15,
  localparam int unsigned                      IDX_W   = $clog2(NUM_VEC)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop_on_fail,
  input  logic             i_clear_fault,
  bist_seq_checker_if.master m_if,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_fault_detected,
  output logic             o_mux_sel,
  output logic [IDX_W:0]   o_fail_count,
  output logic [IDX_W-1:0] o_first_fail_idx
);

  localparam int unsigned ENT_W = WIDTH + 1;
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             r_state,     w_state_nxt;
  logic               r_vec_valid, w_vec_valid_nxt;
  logic [IDX_W-1:0]   r_vec_idx,   w_vec_idx_nxt;
  logic [TMR_W-1:0]   r_timer,     w_timer_nxt;
  logic [ENT_W-1:0]   r_cap,       w_cap_nxt;
  logic               r_timed_out, w_timed_out_nxt;
  logic               r_stop,      w_stop_nxt;
  logic [CNT_W-1:0]   r_fail_cnt,  w_fail_cnt_nxt;
  logic [IDX_W-1:0]   r_first,     w_first_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_done,      w_done_nxt;
  logic               r_pass,      w_pass_nxt;
  logic               r_fault,     w_fault_nxt;
  logic               r_mux,       w_mux_nxt;
  logic               w_mismatch;
  logic [ENT_W-1:0]   w_gold_tab [NUM_VEC];

  // Unpack the flat golden parameter into one entry per vector.
  for (genvar g = 0; g < NUM_VEC; g++) begin : g_gold
    assign w_gold_tab[g] = GOLDEN[g*ENT_W +: ENT_W];
  end

  // Mismatch on timeout or on any differing bit; an unknown compare falls through as a mismatch.
  always_comb begin
    w_mismatch = 1'b1;
    if (!r_timed_out && (r_cap == w_gold_tab[r_vec_idx])) begin
      w_mismatch = 1'b0;
    end
  end

  // Next-state and next-register values for the run sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_vec_valid_nxt = 1'b0;
    w_vec_idx_nxt   = r_vec_idx;
    w_timer_nxt     = r_timer;
    w_cap_nxt       = r_cap;
    w_timed_out_nxt = r_timed_out;
    w_stop_nxt      = r_stop;
    w_fail_cnt_nxt  = r_fail_cnt;
    w_first_nxt     = r_first;
    w_done_nxt      = 1'b0;
    w_pass_nxt      = r_pass;
    w_fault_nxt     = r_fault;
    w_mux_nxt       = r_mux;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_clear_fault) begin
          w_fault_nxt = 1'b0;
          w_mux_nxt   = 1'b0;
        end
        if (i_start) begin
          w_vec_idx_nxt   = '0;
          w_fail_cnt_nxt  = '0;
          w_first_nxt     = '0;
          w_pass_nxt      = 1'b0;
          w_timer_nxt     = '0;
          w_stop_nxt      = i_stop_on_fail;
          w_vec_valid_nxt = 1'b1;
          w_state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_timer_nxt     = '0;
        w_timed_out_nxt = 1'b0;
        w_state_nxt     = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_if.res_valid) begin
          w_cap_nxt   = {m_if.primary_carry, m_if.primary_res};
          w_state_nxt = ST_CHECK;
        end else if (r_timer == TMR_W'(TIMEOUT)) begin
          w_timed_out_nxt = 1'b1;
          w_state_nxt     = ST_CHECK;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ST_CHECK: begin
        if (w_mismatch) begin
          if (r_fail_cnt != CNT_W'(NUM_VEC)) begin
            w_fail_cnt_nxt = r_fail_cnt + CNT_W'(1);
          end
          if (r_fail_cnt == '0) begin
            w_first_nxt = r_vec_idx;
          end
          w_fault_nxt = 1'b1;
          w_mux_nxt   = 1'b1;
        end
        if ((r_vec_idx == IDX_W'(NUM_VEC - 1)) || (w_mismatch && r_stop)) begin
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_fail_cnt_nxt == '0);
          w_state_nxt = ST_DONE;
        end else begin
          w_vec_idx_nxt   = r_vec_idx + IDX_W'(1);
          w_vec_valid_nxt = 1'b1;
          w_state_nxt     = ST_ISSUE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT) ||
                 (w_state_nxt == ST_CHECK);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vec_valid <= 1'b0;
      r_vec_idx   <= '0;
      r_timer     <= '0;
      r_cap       <= '0;
      r_timed_out <= 1'b0;
      r_stop      <= 1'b0;
      r_fail_cnt  <= '0;
      r_first     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fault     <= 1'b0;
      r_mux       <= 1'b0;
    end else begin
      r_vec_valid <= w_vec_valid_nxt;
      r_vec_idx   <= w_vec_idx_nxt;
      r_timer     <= w_timer_nxt;
      r_cap       <= w_cap_nxt;
      r_timed_out <= w_timed_out_nxt;
      r_stop      <= w_stop_nxt;
      r_fail_cnt  <= w_fail_cnt_nxt;
      r_first     <= w_first_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_fault     <= w_fault_nxt;
      r_mux       <= w_mux_nxt;
    end
  end

  assign m_if.vec_valid   = r_vec_valid;
  assign m_if.vec_idx     = r_vec_idx;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_fault_detected = r_fault;
  assign o_mux_sel        = r_mux;
  assign o_fail_count     = r_fail_cnt;
  assign o_first_fail_idx = r_first;

endmodule
